// File: rtl/i2c_cmd_arbiter_if.sv
// Requester handshake and i2c_controller connections of the command arbiter.
// The arbiter binds to the slave modport; requesters/controller sit on master.
interface i2c_cmd_arbiter_if #(
    parameter int NREQ = 2
) ();
    logic [NREQ-1:0]    req_valid;
    logic [24*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    resp_valid;
    logic               resp_ok;
    logic               resp_timeout;
    logic [3:0]         resp_attempts;
    logic [23:0]        i2c_data;
    logic               i2c_start;
    logic               i2c_done;
    logic               i2c_ack;
    logic               busy;

    modport master (
        output req_valid, req_data, i2c_done, i2c_ack,
        input  req_ready, resp_valid, resp_ok, resp_timeout, resp_attempts,
               i2c_data, i2c_start, busy
    );

    modport slave (
        input  req_valid, req_data, i2c_done, i2c_ack,
        output req_ready, resp_valid, resp_ok, resp_timeout, resp_attempts,
               i2c_data, i2c_start, busy
    );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NREQ requesters,
// with NACK retry, a WAIT watchdog and a one-cycle per-requester response.
module i2c_cmd_arbiter #(
    parameter int NREQ           = 2,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic              clk,
    input logic              reset,
    i2c_cmd_arbiter_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [4:0]  RETRY_LIMIT = 5'(MAX_RETRY);
    // Watchdog value on the cycle whose edge would bring it to TIMEOUT_CYCLES-1.
    localparam logic [15:0] WD_LAST     = 16'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARM,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [23:0]     frame;
    logic [4:0]      attempts;
    logic [15:0]     wd;
    logic            ok_q;
    logic            timeout_q;
    logic [3:0]      attempts_q;

    logic            grant_any;
    logic [PW-1:0]   grant_idx;
    logic [PW:0]     scan_sum;
    logic [23:0]     req_frame [NREQ];
    logic [NREQ-1:0] ready_vec;
    logic [NREQ-1:0] resp_vec;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_frame[i] = bus.req_data[24*i +: 24];
        end
    end

    // Scan upward from the pointer with wrap; the first pending requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, ptr} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NREQ)) begin
                scan_sum = scan_sum - (PW+1)'(NREQ);
            end
            if (!grant_any && bus.req_valid[scan_sum[PW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        ready_vec  = '0;
        resp_vec   = '0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_next = LAUNCH;
                    if (!reset) begin
                        ready_vec[grant_idx] = 1'b1;
                    end
                end
            end
            LAUNCH: state_next = ARM;
            ARM:    state_next = WAIT;
            WAIT: begin
                if (bus.i2c_done) begin
                    if (!bus.i2c_ack && attempts <= RETRY_LIMIT) begin
                        state_next = LAUNCH;
                    end else begin
                        state_next = RESP;
                    end
                end else if (wd == WD_LAST) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_vec[owner] = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Done is checked before the watchdog so a completion on the limit cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            frame      <= '0;
            attempts   <= '0;
            wd         <= '0;
            ok_q       <= 1'b0;
            timeout_q  <= 1'b0;
            attempts_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner    <= grant_idx;
                        frame    <= req_frame[grant_idx];
                        attempts <= 5'd1;
                        ptr      <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
                    end
                end
                LAUNCH: wd <= '0;
                WAIT: begin
                    wd <= wd + 16'd1;
                    if (bus.i2c_done) begin
                        if (bus.i2c_ack) begin
                            ok_q       <= 1'b1;
                            timeout_q  <= 1'b0;
                            attempts_q <= attempts[3:0];
                        end else if (attempts <= RETRY_LIMIT) begin
                            attempts <= attempts + 5'd1;
                        end else begin
                            ok_q       <= 1'b0;
                            timeout_q  <= 1'b0;
                            attempts_q <= attempts[3:0];
                        end
                    end else if (wd == WD_LAST) begin
                        ok_q       <= 1'b0;
                        timeout_q  <= 1'b1;
                        attempts_q <= attempts[3:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready     = ready_vec;
    assign bus.resp_valid    = resp_vec;
    assign bus.resp_ok       = ok_q;
    assign bus.resp_timeout  = timeout_q;
    assign bus.resp_attempts = attempts_q;
    assign bus.i2c_data      = frame;
    assign bus.i2c_start     = (state == LAUNCH);
    assign bus.busy          = (state != IDLE);

endmodule
